// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM serial link, used by both the
// sending multiplexer and the receiving-side framer.
package tdm_pkg;
    localparam int NUM_SLOTS = 32;
    localparam int SEL_W     = 5;
    localparam int DIV_W     = 8;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// DIV-cycle divider plus 5-bit slot index; clear dominates run, and the index
// wraps to 0 only through frame end.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic [SEL_W-1:0] slot,
    output logic             slot_end,
    output logic             frame_end,
    output logic             frame_end_nxt
);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [SEL_W-1:0] slot_q, slot_d;

    assign slot      = slot_q;
    assign slot_end  = (div_q == DIV_LAST);
    assign frame_end = slot_end && (slot_q == LAST_SLOT);

    always_comb begin
        div_d  = div_q;
        slot_d = slot_q;
        if (clear) begin
            div_d  = '0;
            slot_d = '0;
        end else if (run) begin
            if (slot_end) begin
                div_d  = '0;
                slot_d = frame_end ? '0 : slot_q + 1'b1;
            end else begin
                div_d  = div_q + 1'b1;
            end
        end
    end

    // Lookahead lets the owner register a done flag aligned with the last cycle.
    assign frame_end_nxt = (slot_d == LAST_SLOT) && (div_d == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            slot_q <= '0;
        end else begin
            div_q  <= div_d;
            slot_q <= slot_d;
        end
    end
endmodule

// File: rtl/mux32x1_tdm.sv
// Time-division 32:1 mux: captures a word on load and serializes bit i in slot i
// with registered outputs; a load on the done cycle chains frames with no gap.
module mux32x1_tdm
    import tdm_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [NUM_SLOTS-1:0] din,
    output logic                 ready,
    output logic                 y,
    output logic [SEL_W-1:0]     sel,
    output logic                 valid,
    output logic                 frame_start,
    output logic                 done
);
    state_e               state_q, state_d;
    logic [NUM_SLOTS-1:0] shadow_q, shadow_d;
    logic                 y_q, y_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 frame_start_q, frame_start_d;
    logic                 done_q, done_d;

    logic             accept;
    logic [SEL_W-1:0] slot;
    logic [SEL_W-1:0] slot_inc;
    logic             slot_end;
    logic             frame_end;
    logic             frame_end_nxt;

    tdm_slot_counter #(.DIV(DIV)) u_slot_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (accept),
        .run           (state_q == SEND),
        .slot          (slot),
        .slot_end      (slot_end),
        .frame_end     (frame_end),
        .frame_end_nxt (frame_end_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (frame_end) state_d = accept ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state_q == IDLE) || frame_end;
        accept = load && ready;
    end

    assign slot_inc = slot + 1'b1;

    // sel/y move only at slot boundaries or on capture, so they hold for DIV cycles.
    always_comb begin
        shadow_d      = accept ? din : shadow_q;
        sel_d         = sel_q;
        y_d           = y_q;
        if (accept) begin
            sel_d = '0;
            y_d   = din[0];
        end else if (state_q == SEND && slot_end) begin
            sel_d = frame_end ? '0 : slot_inc;
            y_d   = frame_end ? 1'b0 : shadow_q[slot_inc];
        end
        valid_d       = (state_d == SEND);
        frame_start_d = accept;
        done_d        = (state_d == SEND) && frame_end_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            y_q           <= 1'b0;
            sel_q         <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            y_q           <= y_d;
            sel_q         <= sel_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign y           = y_q;
    assign sel         = sel_q;
    assign valid       = valid_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;
endmodule

// File: tb/tb_mux32x1_tdm.sv
// Directed bench for mux32x1_tdm with DIV=1 and DIV=3 instances on a shared clock/reset.
module tb_mux32x1_tdm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load1 = 1'b0, load3 = 1'b0;
    logic [31:0] din1 = '0, din3 = '0;

    logic       rdy1, y1, vld1, fs1, dn1;
    logic [4:0] sel1;
    logic       rdy3, y3, vld3, fs3, dn3;
    logic [4:0] sel3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux32x1_tdm #(.DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .din(din1), .ready(rdy1),
        .y(y1), .sel(sel1), .valid(vld1), .frame_start(fs1), .done(dn1)
    );

    mux32x1_tdm #(.DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .load(load3), .din(din3), .ready(rdy3),
        .y(y3), .sel(sel3), .valid(vld3), .frame_start(fs3), .done(dn3)
    );

    // Packed view: {ready, valid, y, sel[4:0], frame_start, done}
    wire [9:0] obs1 = {rdy1, vld1, y1, sel1, fs1, dn1};
    wire [9:0] obs3 = {rdy3, vld3, y3, sel3, fs3, dn3};

    localparam logic [9:0] IDLE_OBS = 10'b10_0_00000_0_0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (obs1 !== IDLE_OBS) begin
                failures++;
                $display("FAIL reset_idle_div1 c=%0d got=%b exp=%b", c, obs1, IDLE_OBS);
            end
            checks++;
            if (obs3 !== IDLE_OBS) begin
                failures++;
                $display("FAIL reset_idle_div3 c=%0d got=%b exp=%b", c, obs3, IDLE_OBS);
            end
            checks++;
        end
    endtask

    task automatic test_div1_frame();
        logic [31:0] d;
        logic [9:0]  exp;
        d = 32'hA5A5_0F0F;
        din1 = d;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            exp = {c == 31, 1'b1, d[c], 5'(c), c == 0, c == 31};
            if (obs1 !== exp) begin
                failures++;
                $display("FAIL div1_frame c=%0d got=%b exp=%b", c, obs1, exp);
            end
            checks++;
            step();
        end
        if (obs1 !== IDLE_OBS) begin
            failures++;
            $display("FAIL div1_after got=%b exp=%b", obs1, IDLE_OBS);
        end
        checks++;
    endtask

    task automatic test_div3_frame();
        logic [31:0] d;
        logic [9:0]  exp;
        int          s;
        d = 32'h8000_0001;
        din3 = d;
        load3 = 1'b1;
        step();
        load3 = 1'b0;
        for (int c = 0; c < 96; c++) begin
            s = c / 3;
            exp = {c == 95, 1'b1, d[s], 5'(s), c == 0, c == 95};
            if (obs3 !== exp) begin
                failures++;
                $display("FAIL div3_frame c=%0d got=%b exp=%b", c, obs3, exp);
            end
            checks++;
            step();
        end
        if (obs3 !== IDLE_OBS) begin
            failures++;
            $display("FAIL div3_after got=%b exp=%b", obs3, IDLE_OBS);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        logic       edge_c;
        din1 = 32'hFFFF_FFFF;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int c = 0; c < 64; c++) begin
            edge_c = (c == 31) || (c == 63);
            exp = {edge_c, 1'b1, c < 32, 5'(c % 32), (c == 0) || (c == 32), edge_c};
            if (obs1 !== exp) begin
                failures++;
                $display("FAIL b2b c=%0d got=%b exp=%b", c, obs1, exp);
            end
            checks++;
            if (c == 31) begin
                din1 = 32'h0000_0000;
                load1 = 1'b1;
            end
            step();
            load1 = 1'b0;
        end
        if (obs1 !== IDLE_OBS) begin
            failures++;
            $display("FAIL b2b_after got=%b exp=%b", obs1, IDLE_OBS);
        end
        checks++;
    endtask

    task automatic test_ignored_load();
        logic [31:0] d;
        logic [9:0]  exp;
        d = 32'h1234_5678;
        din1 = d;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            exp = {c == 31, 1'b1, d[c], 5'(c), c == 0, c == 31};
            if (obs1 !== exp) begin
                failures++;
                $display("FAIL ignored_load c=%0d got=%b exp=%b", c, obs1, exp);
            end
            checks++;
            if (c == 10) begin
                din1 = 32'hDEAD_BEEF;
                load1 = 1'b1;
            end
            step();
            load1 = 1'b0;
        end
        if (obs1 !== IDLE_OBS) begin
            failures++;
            $display("FAIL ignored_load_after got=%b exp=%b", obs1, IDLE_OBS);
        end
        checks++;
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        din1 = 32'hFFFF_FFFF;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int c = 0; c < 17; c++) step();
        exp = {1'b0, 1'b1, 1'b1, 5'd17, 1'b0, 1'b0};
        if (obs1 !== exp) begin
            failures++;
            $display("FAIL midframe_slot17 got=%b exp=%b", obs1, exp);
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if (obs1 !== IDLE_OBS) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", obs1, IDLE_OBS);
        end
        checks++;
        step();
        step();
        rst_n = 1'b1;
        step();
        if (obs1 !== IDLE_OBS) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=%b", obs1, IDLE_OBS);
        end
        checks++;
        din1 = 32'h0000_0003;
        load1 = 1'b1;
        step();
        load1 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            exp = {c == 31, 1'b1, c < 2, 5'(c), c == 0, c == 31};
            if (obs1 !== exp) begin
                failures++;
                $display("FAIL post_reset_frame c=%0d got=%b exp=%b", c, obs1, exp);
            end
            checks++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_div1_frame();
        test_div3_frame();
        test_back_to_back();
        test_ignored_load();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
